i3_router_fifo_rdctrl: RTL
==========================

I3_ROUTER_FIFO_RDCTRL -- requirements
Module: i3_router_FIFO_rdctrl

Interface
REQ-001 Parameter DATA_W, default 32, width of the flit payload.
REQ-002 Parameter TIMEOUT, default 255, count of consecutive stalled cycles that sets stall_timeout.
REQ-003 The design SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 FIFO_empty  input  1  output FIFO has no flit.
REQ-007 FIFO_head  input  3  flit code at the FIFO front; first-word-fall-through, valid while !FIFO_empty.
REQ-008 FIFO_dout  input  DATA_W  payload at the FIFO front.
REQ-009 FIFO_rd  output  1  pop request; the FIFO pops on the rising edge that samples it high.
REQ-010 output_req  output  1  a flit is presented to the downstream router.
REQ-011 output_head  output  3  code of the presented flit.
REQ-012 output_data  output  DATA_W  payload of the presented flit.
REQ-013 output_bussy  input  1  downstream is busy; low means it accepts the presented flit.
REQ-014 proto_err  output  1  sticky packet-protocol violation flag.
REQ-015 stall_timeout  output  1  sticky downstream-stall watchdog flag.
REQ-016 pkt_cnt  output  16  count of packets delivered downstream; wraps.

Function
REQ-017 Flit codes SHALL be 001 head, 010 body, 110 tail; any other code is illegal.
REQ-018 Transfer SHALL occur in a cycle with output_req=1 and output_bussy=0.
- output_head and output_data SHALL be held stable while output_req=1 and no transfer occurs.
REQ-019 The output FSM SHALL have two states: EMPTY and FULL.
- EMPTY: output register empty; output_req=0.
- FULL: output register holds a flit; output_req=1.
REQ-020 FIFO_rd SHALL equal !FIFO_empty && (state==EMPTY || transfer), combinationally.
REQ-021 When FIFO_rd=1, the register SHALL load FIFO_head/FIFO_dout and the FSM SHALL enter or stay in FULL.
- Latency: FIFO becomes non-empty at cycle t in EMPTY; output_req goes high at t+1.
REQ-022 When transfer=1 and FIFO_empty=1, the FSM SHALL go FULL->EMPTY.
REQ-023 Throughput SHALL be one flit per cycle while FIFO_empty=0 and output_bussy=0.
REQ-024 A packet tracker (OUT_PKT/IN_PKT) SHALL update on each pop:
- head: enter IN_PKT;
- tail: enter OUT_PKT;
- body: no change.
REQ-025 proto_err SHALL set on a pop of any of:
- head while IN_PKT;
- body or tail while OUT_PKT;
- an illegal code.
The flit SHALL still be forwarded unchanged.
REQ-026 pkt_cnt SHALL increment on transfer of a tail flit; it wraps from 0xFFFF to 0.
REQ-027 The stall counter SHALL increment each cycle with output_req=1 and output_bussy=1, and clear on transfer or in EMPTY.
- Reaching TIMEOUT SHALL set stall_timeout.
- The counter SHALL saturate.
REQ-028 proto_err and stall_timeout SHALL clear only on reset.

Reset
REQ-029 While rst_n=0, the block SHALL hold:
- FSM in EMPTY, tracker in OUT_PKT;
- output_req, output_head, output_data, FIFO_rd, proto_err, stall_timeout, pkt_cnt and stall counter all 0.
REQ-030 Reset asserted mid-packet SHALL discard the held flit without a pop; after release the tracker expects a head flit.
REQ-031 FIFO_rd SHALL be 0 in the first cycle after rst_n rises only if FIFO_empty=1; no other gating applies.

Structure
REQ-032 Flit codes (HEAD, BODY, TAIL), FSM and tracker state encodings SHALL live in the shared i3_router package, also used by i3_router_FIFO_wrctrl.
REQ-033 The watchdog SHALL be one sub-module, i3_router_stall_wdog, parameterised by TIMEOUT.

Verification
REQ-034 Reset released; FIFO gives head(0xA), body(0xB), tail(0xC) back-to-back; output_bussy=0.
- Required: output_req high for 3 consecutive cycles with data A,B,C; FIFO_rd high for 3 cycles; pkt_cnt=1; proto_err=0.
REQ-035 Same packet with output_bussy=1 for 4 cycles on the body flit.
- Required: output_data stays 0xB for 5 cycles; FIFO_rd=0 during the stall; stall_timeout=0.
REQ-036 output_bussy held 1 for TIMEOUT cycles with a flit presented.
- Required: stall_timeout=1 from the next cycle; it stays 1 after output_bussy falls.
REQ-037 Body flit popped first after reset, then head followed by a second head.
- Required: proto_err=1 after the first pop; both flits still forwarded.
REQ-038 rst_n pulsed low while FULL mid-packet.
- Required: output_req=0 immediately; no pop during reset; a subsequent head is accepted with proto_err=0.
REQ-039 Deliver 65536 packets.
- Required: pkt_cnt wraps to 0.

Source files
------------

// File: rtl/i3_router_pkg.sv
// Shared i3_router definitions: flit codes, output/tracker state encodings and
// the packet-protocol rules used by the FIFO read and write controllers.
package i3_router_pkg;

  localparam logic [2:0] FLIT_HEAD = 3'b001;
  localparam logic [2:0] FLIT_BODY = 3'b010;
  localparam logic [2:0] FLIT_TAIL = 3'b110;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  typedef enum logic {
    TRK_OUT_PKT = 1'b0,
    TRK_IN_PKT  = 1'b1
  } trk_state_e;

  // True when popping a flit with this code breaks head/body/tail framing.
  function automatic logic flit_violates(input trk_state_e trk, input logic [2:0] code);
    case (code)
      FLIT_HEAD: return (trk == TRK_IN_PKT);
      FLIT_BODY,
      FLIT_TAIL: return (trk == TRK_OUT_PKT);
      default:   return 1'b1;
    endcase
  endfunction

  function automatic trk_state_e trk_after(input trk_state_e trk, input logic [2:0] code);
    case (code)
      FLIT_HEAD: return TRK_IN_PKT;
      FLIT_TAIL: return TRK_OUT_PKT;
      default:   return trk;
    endcase
  endfunction

endpackage

// File: rtl/i3_router_stall_wdog.sv
// Downstream-stall watchdog: saturating count of consecutive stalled cycles
// with a sticky flag once TIMEOUT cycles have been reached.
module i3_router_stall_wdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stall,
  output logic stall_timeout
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             timeout_reg, timeout_next;

  // Any non-stalled cycle is either a transfer or an empty output register,
  // both of which restart the count.
  always_comb begin
    cnt_next     = '0;
    timeout_next = timeout_reg;
    if (stall) begin
      cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_W'(1);
      if (cnt_next == CNT_MAX) timeout_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg     <= '0;
      timeout_reg <= 1'b0;
    end else begin
      cnt_reg     <= cnt_next;
      timeout_reg <= timeout_next;
    end
  end

  assign stall_timeout = timeout_reg;

endmodule

// File: rtl/i3_router_fifo_rdctrl.sv
// Router output-FIFO read controller: one-entry output register feeding the
// downstream router, with packet framing checks, packet counter and watchdog.
module i3_router_fifo_rdctrl
  import i3_router_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              FIFO_empty,
  input  logic [2:0]        FIFO_head,
  input  logic [DATA_W-1:0] FIFO_dout,
  output logic              FIFO_rd,
  output logic              output_req,
  output logic [2:0]        output_head,
  output logic [DATA_W-1:0] output_data,
  input  logic              output_bussy,
  output logic              proto_err,
  output logic              stall_timeout,
  output logic [15:0]       pkt_cnt
);

  out_state_e        state_reg, state_next;
  trk_state_e        trk_reg, trk_next;
  logic [2:0]        head_reg;
  logic [DATA_W-1:0] data_reg;
  logic              err_reg, err_next;
  logic [15:0]       pkt_cnt_reg;
  logic              transfer;
  logic              pop_req;

  assign transfer = (state_reg == OUT_FULL) && !output_bussy;

  always_comb begin
    state_next = state_reg;
    pop_req    = 1'b0;
    case (state_reg)
      OUT_EMPTY: begin
        if (!FIFO_empty) begin
          pop_req    = 1'b1;
          state_next = OUT_FULL;
        end
      end
      OUT_FULL: begin
        if (transfer) begin
          if (!FIFO_empty) pop_req = 1'b1;
          else             state_next = OUT_EMPTY;
        end
      end
      default: state_next = OUT_EMPTY;
    endcase
  end

  // The state register already sits in EMPTY during reset; rst_n keeps the
  // FIFO from popping while the controller is held.
  assign FIFO_rd = pop_req && rst_n;

  always_comb begin
    trk_next = trk_reg;
    err_next = err_reg;
    if (pop_req) begin
      if (flit_violates(trk_reg, FIFO_head)) err_next = 1'b1;
      trk_next = trk_after(trk_reg, FIFO_head);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= OUT_EMPTY;
      trk_reg     <= TRK_OUT_PKT;
      err_reg     <= 1'b0;
      head_reg    <= '0;
      data_reg    <= '0;
      pkt_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      trk_reg   <= trk_next;
      err_reg   <= err_next;
      if (pop_req) begin
        head_reg <= FIFO_head;
        data_reg <= FIFO_dout;
      end
      if (transfer && (head_reg == FLIT_TAIL)) pkt_cnt_reg <= pkt_cnt_reg + 16'd1;
    end
  end

  i3_router_stall_wdog #(
    .TIMEOUT(TIMEOUT)
  ) u_stall_wdog (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (output_req && output_bussy),
    .stall_timeout(stall_timeout)
  );

  assign output_req  = (state_reg == OUT_FULL);
  assign output_head = head_reg;
  assign output_data = data_reg;
  assign proto_err   = err_reg;
  assign pkt_cnt     = pkt_cnt_reg;

endmodule
